// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer in front of the single-port data memory.
// Define DMEM_ARB_RR_EN for round-robin tie-break; default is fixed priority to requester 0.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req0_i,
  input  logic                  lock0_i,
  input  logic [3:0]            ctrl0_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  output logic                  gnt0_o,
  output logic                  rvalid0_o,
  output logic [DATA_WIDTH-1:0] rdata0_o,
  input  logic                  req1_i,
  input  logic                  lock1_i,
  input  logic [3:0]            ctrl1_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  output logic                  gnt1_o,
  output logic                  rvalid1_o,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic [3:0]            mem_rw_ctrl_o,
  output logic [ADDR_WIDTH-1:0] mem_waddr_o,
  output logic [ADDR_WIDTH-1:0] mem_raddr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t state_q, state_d;
  logic   last_q;
  logic   tie_pick1;

`ifdef DMEM_ARB_RR_EN
  assign tie_pick1 = ~last_q;
`else
  assign tie_pick1 = 1'b0;
`endif

  always_comb begin
    gnt0_o  = 1'b0;
    gnt1_o  = 1'b0;
    state_d = IDLE;
    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          if (req0_i && (!req1_i || !tie_pick1)) gnt0_o = 1'b1;
          else if (req1_i)                       gnt1_o = 1'b1;
        end
        OWN0:    gnt0_o = req0_i;
        OWN1:    gnt1_o = req1_i;
        default: ;
      endcase
    end
    // Ownership persists only while the owner is granted and still locking.
    if (gnt0_o && lock0_i)      state_d = OWN0;
    else if (gnt1_o && lock1_i) state_d = OWN1;
  end

  always_comb begin
    mem_rw_ctrl_o = '0;
    mem_waddr_o   = '0;
    mem_raddr_o   = '0;
    mem_wdata_o   = '0;
    if (gnt0_o) begin
      mem_rw_ctrl_o = ctrl0_i;
      mem_waddr_o   = addr0_i;
      mem_raddr_o   = addr0_i;
      mem_wdata_o   = wdata0_i;
    end else if (gnt1_o) begin
      mem_rw_ctrl_o = ctrl1_i;
      mem_waddr_o   = addr1_i;
      mem_raddr_o   = addr1_i;
      mem_wdata_o   = wdata1_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      rvalid0_o <= 1'b0;
      rvalid1_o <= 1'b0;
      rdata0_o  <= '0;
      rdata1_o  <= '0;
    end else begin
      state_q   <= state_d;
      if (gnt0_o)      last_q <= 1'b0;
      else if (gnt1_o) last_q <= 1'b1;
      rvalid0_o <= gnt0_o & ~ctrl0_i[3];
      rvalid1_o <= gnt1_o & ~ctrl1_i[3];
      if (gnt0_o && !ctrl0_i[3]) rdata0_o <= mem_rdata_i;
      if (gnt1_o && !ctrl1_i[3]) rdata1_o <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: scenario tasks plus a read-response scoreboard.
// Honours DMEM_ARB_RR_EN the same way the design does.
module tb_dmem_arbiter;

  logic        clk, rst;
  logic        req0, lock0, req1, lock1;
  logic [3:0]  ctrl0, ctrl1;
  logic [7:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic [3:0]  mem_rw_ctrl;
  logic [7:0]  mem_waddr, mem_raddr;
  logic [31:0] mem_wdata, mem_rdata;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;
  logic        tb_last;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] data;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  dmem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .lock0_i(lock0), .ctrl0_i(ctrl0), .addr0_i(addr0), .wdata0_i(wdata0),
    .gnt0_o(gnt0), .rvalid0_o(rvalid0), .rdata0_o(rdata0),
    .req1_i(req1), .lock1_i(lock1), .ctrl1_i(ctrl1), .addr1_i(addr1), .wdata1_i(wdata1),
    .gnt1_o(gnt1), .rvalid1_o(rvalid1), .rdata1_o(rdata1),
    .mem_rw_ctrl_o(mem_rw_ctrl), .mem_waddr_o(mem_waddr), .mem_raddr_o(mem_raddr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Simple single-port memory behind the arbiter.
  assign mem_rdata = mem[mem_raddr];
  always @(posedge clk) if (mem_rw_ctrl[3]) mem[mem_waddr] <= mem_wdata;

  // Scoreboard consumer: each due entry must see rvalid with matching data; otherwise rvalid must be low.
  always @(negedge clk) begin
    checks++;
    if (q0.size() != 0 && q0[0].cyc == cyc) begin
      exp_t e;
      e = q0.pop_front();
      if (rvalid0 !== 1'b1 || rdata0 !== e.data) begin
        errors++;
        $display("FAIL resp0 cyc=%0d: rvalid=%b rdata=%h, expected rvalid=1 rdata=%h", cyc, rvalid0, rdata0, e.data);
      end
    end else if (rvalid0 !== 1'b0) begin
      errors++;
      $display("FAIL resp0_spurious cyc=%0d: rvalid=%b, expected 0", cyc, rvalid0);
    end
    checks++;
    if (q1.size() != 0 && q1[0].cyc == cyc) begin
      exp_t e;
      e = q1.pop_front();
      if (rvalid1 !== 1'b1 || rdata1 !== e.data) begin
        errors++;
        $display("FAIL resp1 cyc=%0d: rvalid=%b rdata=%h, expected rvalid=1 rdata=%h", cyc, rvalid1, rdata1, e.data);
      end
    end else if (rvalid1 !== 1'b0) begin
      errors++;
      $display("FAIL resp1_spurious cyc=%0d: rvalid=%b, expected 0", cyc, rvalid1);
    end
  end

  task automatic drive0(input logic r, input logic l, input logic [3:0] c, input logic [7:0] a, input logic [31:0] d);
    req0 = r; lock0 = l; ctrl0 = c; addr0 = a; wdata0 = d;
  endtask

  task automatic drive1(input logic r, input logic l, input logic [3:0] c, input logic [7:0] a, input logic [31:0] d);
    req1 = r; lock1 = l; ctrl1 = c; addr1 = a; wdata1 = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [7:0] a);
    q0.push_back({32'(cyc + 1), ref_mem[a]});
  endtask

  task automatic push1(input logic [7:0] a);
    q1.push_back({32'(cyc + 1), ref_mem[a]});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive0(1'b1, 1'b0, 4'b0010, 8'd3, 32'h0);
    drive1(1'b1, 1'b0, 4'b0010, 8'd4, 32'h0);
    tick();
    tick();
    checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      errors++; $display("FAIL reset_gnt: gnt0=%b gnt1=%b, expected 0 0", gnt0, gnt1);
    end
    checks++;
    if (mem_rw_ctrl !== 4'b0000 || mem_raddr !== 8'd0) begin
      errors++; $display("FAIL reset_mem: ctrl=%b raddr=%0d, expected 0000 0", mem_rw_ctrl, mem_raddr);
    end
    checks++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
      errors++; $display("FAIL reset_resp: rv0=%b rv1=%b rd0=%h rd1=%h, expected all 0", rvalid0, rvalid1, rdata0, rdata1);
    end
    tb_last = 1'b1;
    drive0(1'b0, 1'b0, 4'b0, 8'd0, 32'h0);
    drive1(1'b0, 1'b0, 4'b0, 8'd0, 32'h0);
    rst = 1'b0;
    tick();
    #1;
    checks++;
    if (mem_rw_ctrl !== 4'b0000 || mem_waddr !== 8'd0 || mem_wdata !== 32'h0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      errors++; $display("FAIL idle_mem: ctrl=%b waddr=%0d wdata=%h gnt=%b%b, expected all 0", mem_rw_ctrl, mem_waddr, mem_wdata, gnt0, gnt1);
    end
  endtask

  task automatic test_write();
    drive0(1'b1, 1'b0, 4'b1010, 8'd5, 32'hDEADBEEF);
    #1;
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++; $display("FAIL write_gnt: gnt0=%b gnt1=%b, expected 1 0", gnt0, gnt1);
    end
    checks++;
    if (mem_rw_ctrl !== 4'b1010 || mem_waddr !== 8'd5 || mem_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_mem: ctrl=%b waddr=%0d wdata=%h, expected 1010 5 deadbeef", mem_rw_ctrl, mem_waddr, mem_wdata);
    end
    ref_mem[5] = 32'hDEADBEEF;
    tb_last = 1'b0;
    tick();
    drive0(1'b0, 1'b0, 4'b0, 8'd0, 32'h0);
    #1;
    checks++;
    if (rvalid0 !== 1'b0) begin
      errors++; $display("FAIL write_no_rvalid: rvalid0=%b, expected 0", rvalid0);
    end
  endtask

  task automatic test_read();
    drive0(1'b1, 1'b0, 4'b0010, 8'd5, 32'h0);
    #1;
    checks++;
    if (gnt0 !== 1'b1 || mem_raddr !== 8'd5 || mem_rw_ctrl !== 4'b0010) begin
      errors++; $display("FAIL read_gnt: gnt0=%b raddr=%0d ctrl=%b, expected 1 5 0010", gnt0, mem_raddr, mem_rw_ctrl);
    end
    push0(8'd5);
    tb_last = 1'b0;
    tick();
    drive0(1'b0, 1'b0, 4'b0, 8'd0, 32'h0);
    #1;
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEADBEEF || rvalid1 !== 1'b0) begin
      errors++; $display("FAIL read_resp: rv0=%b rd0=%h rv1=%b, expected 1 deadbeef 0", rvalid0, rdata0, rvalid1);
    end
    // Requester 1 writes then reads its own word.
    drive1(1'b1, 1'b0, 4'b1010, 8'd9, 32'h1234_5678);
    #1;
    checks++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || mem_waddr !== 8'd9 || mem_wdata !== 32'h1234_5678) begin
      errors++; $display("FAIL write1: gnt1=%b gnt0=%b waddr=%0d wdata=%h, expected 1 0 9 12345678", gnt1, gnt0, mem_waddr, mem_wdata);
    end
    ref_mem[9] = 32'h1234_5678;
    tick();
    drive1(1'b1, 1'b0, 4'b0010, 8'd9, 32'h0);
    #1;
    checks++;
    if (gnt1 !== 1'b1 || mem_raddr !== 8'd9) begin
      errors++; $display("FAIL read1: gnt1=%b raddr=%0d, expected 1 9", gnt1, mem_raddr);
    end
    push1(8'd9);
    tb_last = 1'b1;
    tick();
    drive1(1'b0, 1'b0, 4'b0, 8'd0, 32'h0);
    #1;
  endtask

  task automatic test_contention();
    logic exp1;
    drive0(1'b1, 1'b0, 4'b0010, 8'd5, 32'h0);
    drive1(1'b1, 1'b0, 4'b0010, 8'd9, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
`ifdef DMEM_ARB_RR_EN
      exp1 = ~tb_last;
`else
      exp1 = 1'b0;
`endif
      checks++;
      if (gnt0 !== ~exp1 || gnt1 !== exp1) begin
        errors++; $display("FAIL contention[%0d]: gnt0=%b gnt1=%b, expected %b %b", i, gnt0, gnt1, ~exp1, exp1);
      end
      if (exp1) push1(8'd9);
      else      push0(8'd5);
      tb_last = exp1;
      tick();
    end
    drive0(1'b0, 1'b0, 4'b0, 8'd0, 32'h0);
    drive1(1'b0, 1'b0, 4'b0, 8'd0, 32'h0);
    #1;
  endtask

  task automatic test_lock();
    drive1(1'b1, 1'b1, 4'b0010, 8'd9, 32'h0);
    #1;
    checks++;
    if (gnt1 !== 1'b1) begin
      errors++; $display("FAIL lock_take: gnt1=%b, expected 1", gnt1);
    end
    push1(8'd9);
    tick();
    drive0(1'b1, 1'b0, 4'b0010, 8'd5, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
        errors++; $display("FAIL lock_hold[%0d]: gnt1=%b gnt0=%b, expected 1 0", i, gnt1, gnt0);
      end
      push1(8'd9);
      tick();
    end
    drive1(1'b0, 1'b0, 4'b0, 8'd0, 32'h0);
    #1;
    checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      errors++; $display("FAIL lock_drop: gnt0=%b gnt1=%b, expected 0 0 while still owned", gnt0, gnt1);
    end
    tick();
    #1;
    checks++;
    if (gnt0 !== 1'b1) begin
      errors++; $display("FAIL lock_release: gnt0=%b, expected 1", gnt0);
    end
    push0(8'd5);
    tb_last = 1'b0;
    tick();
    drive0(1'b0, 1'b0, 4'b0, 8'd0, 32'h0);
    #1;
  endtask

  task automatic test_stale_lock();
    drive1(1'b1, 1'b1, 4'b1010, 8'd30, 32'hCAFE_0001);
    #1;
    checks++;
    if (gnt1 !== 1'b1) begin
      errors++; $display("FAIL stale_take: gnt1=%b, expected 1", gnt1);
    end
    ref_mem[30] = 32'hCAFE_0001;
    tick();
    drive1(1'b0, 1'b1, 4'b0010, 8'd30, 32'h0);
    drive0(1'b1, 1'b0, 4'b0010, 8'd30, 32'h0);
    #1;
    checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      errors++; $display("FAIL stale_owned: gnt0=%b gnt1=%b, expected 0 0", gnt0, gnt1);
    end
    tick();
    #1;
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++; $display("FAIL stale_release: gnt0=%b gnt1=%b, expected 1 0", gnt0, gnt1);
    end
    push0(8'd30);
    tb_last = 1'b0;
    tick();
    drive0(1'b0, 1'b0, 4'b0, 8'd0, 32'h0);
    drive1(1'b0, 1'b0, 4'b0, 8'd0, 32'h0);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      drive0(1'b1, 1'b0, 4'b1010, 8'(20 + i), d);
      #1;
      checks++;
      if (gnt0 !== 1'b1 || mem_waddr !== 8'(20 + i) || mem_wdata !== d) begin
        errors++; $display("FAIL b2b_write[%0d]: gnt0=%b waddr=%0d wdata=%h, expected 1 %0d %h", i, gnt0, mem_waddr, mem_wdata, 20 + i, d);
      end
      ref_mem[20 + i] = d;
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive0(1'b1, 1'b0, 4'b0100, 8'(20 + i), 32'h0);
      #1;
      checks++;
      if (gnt0 !== 1'b1 || mem_raddr !== 8'(20 + i)) begin
        errors++; $display("FAIL b2b_read[%0d]: gnt0=%b raddr=%0d, expected 1 %0d", i, gnt0, mem_raddr, 20 + i);
      end
      push0(8'(20 + i));
      tick();
    end
    tb_last = 1'b0;
    drive0(1'b0, 1'b0, 4'b0, 8'd0, 32'h0);
    #1;
  endtask

  task automatic test_reset_mid();
    drive1(1'b1, 1'b1, 4'b0010, 8'd9, 32'h0);
    #1;
    push1(8'd9);
    tick();
    drive0(1'b1, 1'b0, 4'b0010, 8'd5, 32'h0);
    #1;
    checks++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
      errors++; $display("FAIL rstmid_owned: gnt1=%b gnt0=%b, expected 1 0", gnt1, gnt0);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      errors++; $display("FAIL rstmid_gnt: gnt0=%b gnt1=%b, expected 0 0", gnt0, gnt1);
    end
    tick();
    checks++;
    if (rvalid1 !== 1'b0 || rvalid0 !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      errors++; $display("FAIL rstmid_drop: rv1=%b rv0=%b gnt=%b%b, expected 0 0 00", rvalid1, rvalid0, gnt0, gnt1);
    end
    rst = 1'b0;
    tb_last = 1'b1;
    #1;
    // Back in IDLE with last_winner reset: requester 0 wins the tie in either mode.
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle: gnt0=%b gnt1=%b, expected 1 0", gnt0, gnt1);
    end
    push0(8'd5);
    tb_last = 1'b0;
    tick();
    drive0(1'b0, 1'b0, 4'b0, 8'd0, 32'h0);
    drive1(1'b0, 1'b0, 4'b0, 8'd0, 32'h0);
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    tb_last = 1'b1;
    rst = 1'b1;
    drive0(1'b0, 1'b0, 4'b0, 8'd0, 32'h0);
    drive1(1'b0, 1'b0, 4'b0, 8'd0, 32'h0);
    test_reset();
    test_write();
    test_read();
    test_contention();
    test_lock();
    test_stale_lock();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: q0=%0d q1=%0d outstanding, expected 0 0", q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
